// File: rtl/raster_stamp_dispatch_pkg.sv
// Raster stamp/CSR types shared by the stamp dispatch stage and its stamp buffer.
// Holds pos_mask field offsets and the packing helper.
package raster_stamp_dispatch_pkg;

  localparam int RASTER_DIM_BITS = 8;
  localparam int RASTER_PID_BITS = 8;

  localparam int RASTER_POSMASK_X_LSB = 4;
  localparam int RASTER_POSMASK_Y_LSB = RASTER_POSMASK_X_LSB + RASTER_DIM_BITS - 1;

  typedef struct packed {
    logic [RASTER_DIM_BITS-2:0] pos_x;
    logic [RASTER_DIM_BITS-2:0] pos_y;
    logic [3:0]                 mask;
    logic [2:0][31:0]           bcoords;
    logic [RASTER_PID_BITS-1:0] pid;
  } raster_stamp_t;

  typedef struct packed {
    logic [31:0]      pos_mask;
    logic [2:0][31:0] bcoords;
  } raster_csrs_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_RESPOND
  } dispatch_state_e;

  // {zero-pad, pos_y, pos_x, mask}
  function automatic logic [31:0] raster_pack_posmask(
    input logic [RASTER_DIM_BITS-2:0] pos_x,
    input logic [RASTER_DIM_BITS-2:0] pos_y,
    input logic [3:0]                 mask
  );
    raster_pack_posmask = 32'(mask)
                        | (32'(pos_x) << RASTER_POSMASK_X_LSB)
                        | (32'(pos_y) << RASTER_POSMASK_Y_LSB);
  endfunction

endpackage

// File: rtl/raster_stamp_dispatch_fifo.sv
// Stamp buffer: pointer-based FIFO, head is read straight from storage so a
// stamp written in one cycle is visible at the head the next.
module raster_stamp_dispatch_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/raster_stamp_dispatch.sv
// Stamp dispatch: buffers raster stamps and hands one per active lane to a
// requesting warp, signalling "no more work" once the raster pipe is drained.
module raster_stamp_dispatch
  import raster_stamp_dispatch_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int NUM_WARPS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int WID_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   stamp_valid,
  input  raster_stamp_t                          stamp_data,
  output logic                                   stamp_ready,
  input  logic                                   raster_done,
  input  logic                                   req_valid,
  input  logic [WID_BITS-1:0]                    req_wid,
  input  logic [NUM_LANES-1:0]                   req_tmask,
  output logic                                   req_ready,
  output logic                                   rsp_valid,
  output logic [WID_BITS-1:0]                    rsp_wid,
  output logic [NUM_LANES-1:0]                   rsp_tmask,
  output raster_csrs_t [NUM_LANES-1:0]           rsp_csrs,
  output logic [NUM_LANES-1:0][RASTER_PID_BITS-1:0] rsp_pid,
  output logic                                   rsp_empty,
  input  logic                                   rsp_ready
);

  if (2*(RASTER_DIM_BITS-1)+4 > 32) begin : g_posmask_chk
    $error("pos_mask fields do not fit in 32 bits");
  end

  dispatch_state_e state_q, state_d;
  logic [WID_BITS-1:0]                     wid_q, wid_d;
  logic [NUM_LANES-1:0]                    tmask_q, tmask_d;
  logic [NUM_LANES-1:0]                    fill_q, fill_d;
  raster_csrs_t [NUM_LANES-1:0]            csrs_q, csrs_d;
  logic [NUM_LANES-1:0][RASTER_PID_BITS-1:0] pid_q, pid_d;
  logic                                    empty_q, empty_d;

  raster_stamp_t        fifo_head;
  logic                 fifo_empty, fifo_full, fifo_pop;
  logic [NUM_LANES-1:0] avail, lane_sel;

  raster_stamp_dispatch_fifo #(
    .DATA_W ($bits(raster_stamp_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (stamp_valid),
    .push_data (stamp_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Lowest unfilled active lane, as a one-hot.
  assign avail    = tmask_q & ~fill_q;
  assign lane_sel = avail & (~avail + NUM_LANES'(1));

  always_comb begin
    state_d  = state_q;
    wid_d    = wid_q;
    tmask_d  = tmask_q;
    fill_d   = fill_q;
    csrs_d   = csrs_q;
    pid_d    = pid_q;
    empty_d  = empty_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wid_d   = req_wid;
          tmask_d = req_tmask;
          fill_d  = '0;
          csrs_d  = '0;
          pid_d   = '0;
          empty_d = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (!fifo_empty && (avail != '0)) begin
          fifo_pop = 1'b1;
          fill_d   = fill_q | lane_sel;
          for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_sel[i]) begin
              csrs_d[i].pos_mask = raster_pack_posmask(fifo_head.pos_x, fifo_head.pos_y,
                                                       fifo_head.mask);
              csrs_d[i].bcoords  = fifo_head.bcoords;
              pid_d[i]           = fifo_head.pid;
            end
          end
        end
        // Exit decision uses this cycle's fill so k lanes cost exactly k cycles.
        if ((fill_d == tmask_q) || (fifo_empty && raster_done)) begin
          state_d = ST_RESPOND;
          empty_d = (fill_d == '0) && raster_done;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wid_q   <= '0;
      tmask_q <= '0;
      fill_q  <= '0;
      csrs_q  <= '0;
      pid_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wid_q   <= wid_d;
      tmask_q <= tmask_d;
      fill_q  <= fill_d;
      csrs_q  <= csrs_d;
      pid_q   <= pid_d;
      empty_q <= empty_d;
    end
  end

  assign stamp_ready = !fifo_full;
  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESPOND);
  assign rsp_wid     = wid_q;
  assign rsp_tmask   = fill_q;
  assign rsp_csrs    = csrs_q;
  assign rsp_pid     = pid_q;
  assign rsp_empty   = empty_q;

endmodule

// File: doc/raster_stamp_dispatch.md
# raster_stamp_dispatch

Stamp dispatch stage directly downstream of the raster stamp generator. It buffers `raster_stamp_t` quads, serves per-warp stamp-fetch requests from the core's raster CSR path, and returns one `raster_csrs_t` plus primitive index per active lane. Lanes are filled from the FIFO in ascending lane order. When the raster pipeline is drained, it tells the warp that no more work exists.

## Interface
- `NUM_LANES`, 4: threads per warp served per request.
- `NUM_WARPS`, 4: warp-id space; `WID_BITS = $clog2(NUM_WARPS)`, minimum 1.
- `FIFO_DEPTH`, 8: stamp buffer entries, power of two ≥ 2.
- Clocking (already decided): one clock; reset is synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `stamp_valid`  in  1  upstream stamp valid.
- `stamp_data`  in  `$bits(raster_stamp_t)`  stamp payload.
- `stamp_ready`  out  1  FIFO can accept.
- `raster_done`  in  1  level; upstream will produce no further stamps.
- `req_valid`  in  1  warp fetch request.
- `req_wid`  in  `WID_BITS`  requesting warp.
- `req_tmask`  in  `NUM_LANES`  active lanes.
- `req_ready`  out  1  request accepted.
- `rsp_valid`  out  1  response valid.
- `rsp_wid`  out  `WID_BITS`  echoed warp id.
- `rsp_tmask`  out  `NUM_LANES`  lanes that received a stamp.
- `rsp_csrs`  out  `NUM_LANES` × `$bits(raster_csrs_t)`  per-lane CSR values.
- `rsp_pid`  out  `NUM_LANES` × `RASTER_PID_BITS`  per-lane primitive index.
- `rsp_empty`  out  1  `raster_done` held and zero lanes filled.
- `rsp_ready`  in  1  core consumes response.

## Operation
- **FIFO**
  - Push on `stamp_valid & stamp_ready`.
  - `stamp_ready = !full`. No full-with-pop bypass.
  - Push and pop in the same cycle are allowed when neither full nor empty.
- **FSM states:** IDLE, COLLECT, RESPOND.
- **IDLE**
  - `req_ready = 1`.
  - On `req_valid`: latch `wid` and `tmask`, clear the fill mask and all lane registers, then go to COLLECT.
- **COLLECT**
  - Each cycle, if the FIFO is non-empty and an unfilled active lane remains, pop one stamp into the lowest-index unfilled active lane and set its fill bit.
  - Go to RESPOND when the fill mask equals the latched tmask, or when the FIFO is empty and `raster_done = 1`.
  - If the FIFO is empty and `raster_done = 0`, stall in COLLECT.
  - A request with `tmask = 0` passes through COLLECT for one cycle and then goes to RESPOND.
- **RESPOND**
  - `rsp_valid = 1`; all response fields are stable until `rsp_ready`.
  - `rsp_tmask` = fill mask.
  - `rsp_empty = (fill mask == 0) & raster_done`, evaluated at RESPOND entry and registered.
  - On `rsp_ready`, go to IDLE.
- **pos_mask packing**
  - `pos_mask = {zero-pad, pos_y, pos_x, mask}`, with mask at [3:0] and pos_x at [DIM_BITS+2:4].
  - Static assert: `2*(RASTER_DIM_BITS-1)+4 ≤ 32`.
- **Lane fields**
  - `bcoords` is copied verbatim.
  - Unfilled lanes output all-zero csrs and pid.
- `raster_done` is never latched; it is sampled combinationally in COLLECT.

## Timing
- **Reset values**
  - state = IDLE; FIFO empty; `stamp_ready = 1`; `req_ready = 1`.
  - `rsp_valid = 0`, `rsp_empty = 0`.
  - `rsp_tmask`, `rsp_csrs`, `rsp_pid`, `rsp_wid` = 0.
- **Reset mid-operation:** in-flight stamps and requests are discarded; there is no partial response.
- **Latency:** request accepted in cycle T, k active lanes, FIFO holding ≥ k stamps → `rsp_valid` rises in cycle T+1+k.
- **Zero-lane request:** `rsp_valid` in T+2.
- **Stamp flow:** a stamp pushed in cycle T is poppable from T+1.
- **Back-to-back requests:** `req_ready` rises the cycle after `rsp_ready`, giving one idle cycle between responses.
- **Outputs:** all outputs are registered or state-decoded; there is no combinational path from `rsp_ready` to `req_ready`, or from `stamp_valid` to `stamp_ready`.

## Structure
- Add to the `VX_raster_types` package:
  - `RASTER_POSMASK_X_LSB`, `RASTER_POSMASK_Y_LSB` constants;
  - a `raster_pack_posmask` function.
- Sub-module: the codebase `VX_fifo_queue` instance for the stamp buffer.
- Fill-lane selection uses the codebase `VX_priority_encoder` on `tmask & ~fill`.

## Test plan
- Push 4 stamps (pos_x=1..4, mask=4'hF, pid=7), then request tmask=4'b1111 → response in T+5: tmask 1111, lane0 pos_mask=0x0000001F, lane3 pos_x=4, all pid=7.
- Request tmask=4'b1010 with 3 stamps queued → lanes 1 and 3 get stamps 0 and 1; lanes 0 and 2 are zero; one stamp remains in the FIFO.
- 1 stamp queued, tmask=1111, `raster_done` rises 5 cycles later → tmask 0001 after done, `rsp_empty = 0`. Next request → tmask 0000, `rsp_empty = 1`.
- Push 9 stamps with `FIFO_DEPTH = 8` and no request → `stamp_ready` low after 8 pushes. It returns high the cycle after the first pop; data order is preserved.
- Hold `rsp_ready = 0` for 10 cycles → fields stable, `req_ready = 0`, no pops. Assert reset during RESPOND → all outputs at reset values the next cycle.
- Request tmask=0 → `rsp_valid` in T+2, tmask 0, `rsp_empty = raster_done`.
